// File: rtl/fetch_pc_stack_pkg.sv
// Shared constants, encodings and helpers for the fetch stage and its return stack.
// Optional build macro: STACK_ERR_EN (sticky overflow/underflow flags).
package fetch_pc_stack_pkg;

    localparam int PC_W        = 12;
    localparam int INSTR_W     = 19;
    localparam int STACK_DEPTH = 8;
    localparam int SP_W        = $clog2(STACK_DEPTH);
    localparam int DEPTH_W     = SP_W + 1;

    localparam logic [1:0] SEL_BRANCH = 2'b00;
    localparam logic [1:0] SEL_NEXT   = 2'b01;
    localparam logic [1:0] SEL_JUMP   = 2'b10;

    localparam int JUMP_MSB = 11;
    localparam int JUMP_LSB = 0;
    localparam int BR_MSB   = 7;
    localparam int BR_LSB   = 0;

    localparam logic [DEPTH_W-1:0] DEPTH_FULL = DEPTH_W'(STACK_DEPTH);

    typedef enum logic [1:0] {
        ST_EMPTY   = 2'b00,
        ST_PARTIAL = 2'b01,
        ST_FULL    = 2'b10
    } stack_state_e;

    function automatic logic [PC_W-1:0] sext_offset(input logic [BR_MSB-BR_LSB:0] off);
        return {{(PC_W-(BR_MSB-BR_LSB+1)){off[BR_MSB-BR_LSB]}}, off};
    endfunction

endpackage

// File: rtl/fetch_pc_stack_if.sv
// Controller-side bus of the fetch stage; master = controller/imem side, slave = fetch stage.
// Optional build macro: STACK_ERR_EN adds stackOverflow/stackUnderflow.
interface fetch_pc_stack_if;
    import fetch_pc_stack_pkg::*;

    logic                enablePC;
    logic [1:0]          selectAdress;
    logic                push;
    logic                pop;
    logic                RET;
    logic [INSTR_W-1:0]  instrIn;
    logic [PC_W-1:0]     pc;
    logic [INSTR_W-1:0]  allBits;
    logic [DEPTH_W-1:0]  stackDepth;
`ifdef STACK_ERR_EN
    logic                stackOverflow;
    logic                stackUnderflow;
`endif

    modport master (
        output enablePC, selectAdress, push, pop, RET, instrIn,
        input  pc, allBits, stackDepth
`ifdef STACK_ERR_EN
        , input stackOverflow, stackUnderflow
`endif
    );

    modport slave (
        input  enablePC, selectAdress, push, pop, RET, instrIn,
        output pc, allBits, stackDepth
`ifdef STACK_ERR_EN
        , output stackOverflow, stackUnderflow
`endif
    );

endinterface

// File: rtl/fetch_pc_stack_return_stack.sv
// Hardware return-address LIFO: storage, stack pointer, depth FSM and optional error flags.
// Optional build macro: STACK_ERR_EN (drop push on full / sticky flags).
module return_stack
    import fetch_pc_stack_pkg::*;
(
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_push,
    input  logic               i_pop,
    input  logic [PC_W-1:0]    i_wdata,
    output logic [PC_W-1:0]    o_top,
    output logic [DEPTH_W-1:0] o_depth
`ifdef STACK_ERR_EN
    ,
    output logic               o_overflow,
    output logic               o_underflow
`endif
);

    logic [PC_W-1:0]    r_mem [STACK_DEPTH];
    logic [SP_W-1:0]    r_sp;
    logic [DEPTH_W-1:0] r_depth;
    stack_state_e       r_state;
`ifdef STACK_ERR_EN
    logic               r_ovf;
    logic               r_unf;
    logic               w_ovf_set;
    logic               w_unf_set;
`endif

    logic [SP_W-1:0]    w_sp_m1;
    logic               w_wr_en;
    logic [SP_W-1:0]    w_wr_addr;
    logic [SP_W-1:0]    w_sp_nxt;
    logic [DEPTH_W-1:0] w_depth_nxt;
    stack_state_e       w_state_nxt;

    assign w_sp_m1 = r_sp - SP_W'(1);

    // Empty-stack read yields 0, or the fall-through address when error handling is built in.
    always_comb begin
        if (r_state == ST_EMPTY) begin
`ifdef STACK_ERR_EN
            o_top = i_wdata;
`else
            o_top = {PC_W{1'b0}};
`endif
        end else begin
            o_top = r_mem[w_sp_m1];
        end
    end

    // Next-state decode for pointer, depth, write port and flags.
    always_comb begin
        w_wr_en     = 1'b0;
        w_wr_addr   = r_sp;
        w_sp_nxt    = r_sp;
        w_depth_nxt = r_depth;
`ifdef STACK_ERR_EN
        w_ovf_set   = 1'b0;
        w_unf_set   = 1'b0;
`endif
        case ({i_push, i_pop})
            2'b10: begin
                if (r_state != ST_FULL) begin
                    w_wr_en     = 1'b1;
                    w_sp_nxt    = r_sp + SP_W'(1);
                    w_depth_nxt = r_depth + DEPTH_W'(1);
                end else begin
`ifdef STACK_ERR_EN
                    w_ovf_set   = 1'b1;
`else
                    // sp already points at the oldest entry when full
                    w_wr_en     = 1'b1;
                    w_sp_nxt    = r_sp + SP_W'(1);
`endif
                end
            end
            2'b01: begin
                if (r_state != ST_EMPTY) begin
                    w_sp_nxt    = w_sp_m1;
                    w_depth_nxt = r_depth - DEPTH_W'(1);
                end else begin
`ifdef STACK_ERR_EN
                    w_unf_set   = 1'b1;
`endif
                end
            end
            2'b11: begin
                if (r_state != ST_EMPTY) begin
                    w_wr_en     = 1'b1;
                    w_wr_addr   = w_sp_m1;
                end else begin
                    w_wr_en     = 1'b1;
                    w_sp_nxt    = r_sp + SP_W'(1);
                    w_depth_nxt = r_depth + DEPTH_W'(1);
                end
            end
            default: begin
                w_wr_en     = 1'b0;
            end
        endcase

        if (w_depth_nxt == {DEPTH_W{1'b0}}) begin
            w_state_nxt = ST_EMPTY;
        end else if (w_depth_nxt == DEPTH_FULL) begin
            w_state_nxt = ST_FULL;
        end else begin
            w_state_nxt = ST_PARTIAL;
        end
    end

    // Stack registers and depth FSM.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int i = 0; i < STACK_DEPTH; i++) begin
                r_mem[i] <= {PC_W{1'b0}};
            end
            r_sp    <= {SP_W{1'b0}};
            r_depth <= {DEPTH_W{1'b0}};
            r_state <= ST_EMPTY;
`ifdef STACK_ERR_EN
            r_ovf   <= 1'b0;
            r_unf   <= 1'b0;
`endif
        end else begin
            if (w_wr_en) begin
                r_mem[w_wr_addr] <= i_wdata;
            end
            r_sp    <= w_sp_nxt;
            r_depth <= w_depth_nxt;
            r_state <= w_state_nxt;
`ifdef STACK_ERR_EN
            r_ovf   <= r_ovf | w_ovf_set;
            r_unf   <= r_unf | w_unf_set;
`endif
        end
    end

    assign o_depth = r_depth;
`ifdef STACK_ERR_EN
    assign o_overflow  = r_ovf;
    assign o_underflow = r_unf;
`endif

endmodule

// File: rtl/fetch_pc_stack.sv
// Instruction-fetch stage: PC register, next-PC mux and return-stack control.
// Optional build macro: STACK_ERR_EN (exposes stackOverflow/stackUnderflow).
module fetch_pc_stack
    import fetch_pc_stack_pkg::*;
(
    input  logic              clock,
    input  logic              reset,
    fetch_pc_stack_if.slave   bus
);

    logic [PC_W-1:0] r_pc;
    logic [PC_W-1:0] w_pc_plus1;
    logic [PC_W-1:0] w_branch;
    logic [PC_W-1:0] w_jump;
    logic [PC_W-1:0] w_top;
    logic [PC_W-1:0] w_pc_nxt;
    logic            w_push;
    logic            w_pop;

    assign w_pc_plus1 = r_pc + PC_W'(1);
    assign w_branch   = w_pc_plus1 + sext_offset(bus.instrIn[BR_MSB:BR_LSB]);
    assign w_jump     = bus.instrIn[JUMP_MSB:JUMP_LSB];
    assign w_push     = bus.enablePC & bus.push;
    assign w_pop      = bus.enablePC & bus.pop;

    // Next-PC select: return beats jump beats branch beats fall-through.
    always_comb begin
        w_pc_nxt = w_pc_plus1;
        if (bus.RET) begin
            w_pc_nxt = w_top;
        end else begin
            case (bus.selectAdress)
                SEL_JUMP:   w_pc_nxt = w_jump;
                SEL_BRANCH: w_pc_nxt = w_branch;
                SEL_NEXT:   w_pc_nxt = w_pc_plus1;
                default:    w_pc_nxt = w_pc_plus1;
            endcase
        end
    end

    // Program counter register.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_pc <= {PC_W{1'b0}};
        end else if (bus.enablePC) begin
            r_pc <= w_pc_nxt;
        end else begin
            r_pc <= r_pc;
        end
    end

    return_stack u_stack (
        .i_clk       (clock),
        .i_rst       (reset),
        .i_push      (w_push),
        .i_pop       (w_pop),
        .i_wdata     (w_pc_plus1),
        .o_top       (w_top),
        .o_depth     (bus.stackDepth)
`ifdef STACK_ERR_EN
        ,
        .o_overflow  (bus.stackOverflow),
        .o_underflow (bus.stackUnderflow)
`endif
    );

    assign bus.pc      = r_pc;
    assign bus.allBits = bus.instrIn;

endmodule

// File: tb/tb_fetch_pc_stack.sv
// Scoreboard bench for fetch_pc_stack; builds with or without STACK_ERR_EN.
module tb_fetch_pc_stack;
    import fetch_pc_stack_pkg::*;

    logic clock = 1'b0;
    logic reset;
    int   n_checks = 0;
    int   n_errors = 0;

    fetch_pc_stack_if bus ();

    fetch_pc_stack dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    typedef struct {
        int pc;
        int depth;
        bit ovf;
        bit unf;
    } exp_t;

    exp_t sb_q[$];
    int   m_pc;
    int   m_stk[$];
    bit   m_ovf;
    bit   m_unf;
`ifdef STACK_ERR_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic void push_expect();
        exp_t e;
        e.pc    = m_pc;
        e.depth = m_stk.size();
        e.ovf   = m_ovf;
        e.unf   = m_unf;
        sb_q.push_back(e);
    endfunction

    // Reference model of one enabled/disabled cycle, using a queue as the stack.
    function automatic void model_step(input bit en, input logic [1:0] sel, input bit ps,
                                       input bit pp, input bit rt, input logic [18:0] ins);
        int plus1;
        int nxt;
        plus1 = (m_pc + 1) & 32'hFFF;
        if (en) begin
            if (rt) begin
                if (m_stk.size() > 0) nxt = m_stk[$];
                else nxt = ERR_EN ? plus1 : 0;
            end else if (sel == 2'b10) begin
                nxt = int'(ins[11:0]);
            end else if (sel == 2'b00) begin
                nxt = (m_pc + 1 + int'($signed(ins[7:0]))) & 32'hFFF;
            end else begin
                nxt = plus1;
            end
            if (ps && pp && m_stk.size() > 0) begin
                m_stk[m_stk.size()-1] = plus1;
            end else if (ps) begin
                if (m_stk.size() == STACK_DEPTH) begin
                    if (ERR_EN) begin
                        m_ovf = 1'b1;
                    end else begin
                        void'(m_stk.pop_front());
                        m_stk.push_back(plus1);
                    end
                end else begin
                    m_stk.push_back(plus1);
                end
            end else if (pp) begin
                if (m_stk.size() > 0) void'(m_stk.pop_back());
                else if (ERR_EN) m_unf = 1'b1;
            end
            m_pc = nxt;
        end
    endfunction

    task automatic compare_out();
        exp_t e;
        e = sb_q.pop_front();
        check_val("pc", 32'(bus.pc), e.pc);
        check_val("depth", 32'(bus.stackDepth), e.depth);
`ifdef STACK_ERR_EN
        check_val("overflow", 32'(bus.stackOverflow), 32'(e.ovf));
        check_val("underflow", 32'(bus.stackUnderflow), 32'(e.unf));
`endif
    endtask

    task automatic cycle(input bit en, input logic [1:0] sel, input bit ps, input bit pp,
                         input bit rt, input logic [18:0] ins);
        bus.enablePC     = en;
        bus.selectAdress = sel;
        bus.push         = ps;
        bus.pop          = pp;
        bus.RET          = rt;
        bus.instrIn      = ins;
        #1;
        check_val("allBits", 32'(bus.allBits), 32'(ins));
        model_step(en, sel, ps, pp, rt, ins);
        push_expect();
        @(posedge clock);
        #1;
        compare_out();
    endtask

    task automatic do_reset();
        reset            = 1'b1;
        bus.enablePC     = 1'b1;
        bus.selectAdress = SEL_JUMP;
        bus.push         = 1'b1;
        bus.pop          = 1'b0;
        bus.RET          = 1'b0;
        bus.instrIn      = 19'h00555;
        m_pc  = 0;
        m_stk.delete();
        m_ovf = 1'b0;
        m_unf = 1'b0;
        push_expect();
        @(posedge clock);
        #1;
        reset = 1'b0;
        compare_out();
    endtask

    task automatic jump(input logic [11:0] tgt);
        cycle(1'b1, SEL_JUMP, 1'b0, 1'b0, 1'b0, {7'h00, tgt});
    endtask

    task automatic call(input logic [11:0] tgt);
        cycle(1'b1, SEL_JUMP, 1'b1, 1'b0, 1'b0, {7'h00, tgt});
    endtask

    task automatic ret();
        cycle(1'b1, SEL_NEXT, 1'b0, 1'b1, 1'b1, 19'h00000);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        @(posedge clock);
        #1;
        do_reset();
        check_val("reset_pc", 32'(bus.pc), 32'h0);

        for (int i = 0; i < 3; i++) begin
            cycle(1'b1, SEL_NEXT, 1'b0, 1'b0, 1'b0, 19'($urandom));
        end
        check_val("seq_pc", 32'(bus.pc), 32'h3);

        jump(12'h010);
        cycle(1'b1, SEL_BRANCH, 1'b0, 1'b0, 1'b0, 19'h7A0FC);
        check_val("branch_back", 32'(bus.pc), 32'h00D);
        jump(12'h010);
        cycle(1'b1, SEL_BRANCH, 1'b0, 1'b0, 1'b0, 19'h00305);
        check_val("branch_fwd", 32'(bus.pc), 32'h016);

        jump(12'h020);
        call(12'h300);
        check_val("call_pc", 32'(bus.pc), 32'h300);
        check_val("call_depth", 32'(bus.stackDepth), 32'h1);
        cycle(1'b1, SEL_NEXT, 1'b0, 1'b0, 1'b0, 19'h00000);
        ret();
        check_val("ret_pc", 32'(bus.pc), 32'h021);
        check_val("ret_depth", 32'(bus.stackDepth), 32'h0);

        for (int i = 0; i < 9; i++) begin
            call(12'(12'h100 + i * 16));
        end
        check_val("nest_depth", 32'(bus.stackDepth), 32'h8);
        for (int i = 0; i < 8; i++) begin
            ret();
        end

        jump(12'h040);
        ret();
        check_val("empty_ret_pc", 32'(bus.pc), ERR_EN ? 32'h041 : 32'h000);

        jump(12'h0A0);
        call(12'h0B0);
        cycle(1'b0, SEL_JUMP, 1'b1, 1'b0, 1'b0, 19'h00777);
        check_val("hold_pc", 32'(bus.pc), 32'h0B0);
        cycle(1'b1, SEL_JUMP, 1'b1, 1'b1, 1'b0, 19'h00200);
        call(12'h0C0);
        call(12'h0D0);
        check_val("pre_reset_depth", 32'(bus.stackDepth), 32'h3);
        do_reset();

        jump(12'hFFF);
        cycle(1'b1, SEL_NEXT, 1'b0, 1'b0, 1'b0, 19'h00000);
        check_val("wrap_pc", 32'(bus.pc), 32'h000);

        for (int i = 0; i < 80; i++) begin
            logic [1:0] sel;
            bit ps;
            bit pp;
            bit rt;
            sel = 2'($urandom_range(0, 3));
            ps  = ($urandom_range(0, 3) == 0);
            pp  = ($urandom_range(0, 3) == 0);
            rt  = pp ? ($urandom_range(0, 1) == 1) : ($urandom_range(0, 7) == 0);
            cycle(($urandom_range(0, 5) != 0), sel, ps, pp, rt, 19'($urandom));
        end

        if (sb_q.size() != 0) begin
            check_val("scoreboard_drain", 32'(sb_q.size()), 32'h0);
        end
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
